// File: rtl/alu_system.sv
// alu_system: general-purpose RF, address RF, 16-bit IR, 8-bit ALU with flags, 256x8 memory and source muxes.
// Latency: register, flag and memory updates land on the rising Clock edge; every read path is combinational.
// Backpressure: none; each select/enable takes effect on the edge where it is presented.
module alu_system (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [2:0] RF_O1Sel,
  input  logic [2:0] RF_O2Sel,
  input  logic [1:0] RF_FunSel,
  input  logic [3:0] RF_RSel,
  input  logic [3:0] RF_TSel,
  input  logic [3:0] ALU_FunSel,
  input  logic [1:0] ARF_OutASel,
  input  logic [1:0] ARF_OutBSel,
  input  logic [1:0] ARF_FunSel,
  input  logic [3:0] ARF_RSel,
  input  logic       IR_LH,
  input  logic       IR_Enable,
  input  logic [1:0] IR_FunSel,
  input  logic       Mem_WR,
  input  logic       Mem_CS,
  input  logic [1:0] MuxASel,
  input  logic [1:0] MuxBSel,
  input  logic       MuxCSel
);

  // Register function codes shared by RF, ARF and IR.
  localparam logic [1:0] FUN_DEC  = 2'b00;
  localparam logic [1:0] FUN_INC  = 2'b01;
  localparam logic [1:0] FUN_LOAD = 2'b10;
  localparam logic [1:0] FUN_CLR  = 2'b11;

  // Mux source codes, identical for MuxA and MuxB.
  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_IR   = 2'b10;
  localparam logic [1:0] SRC_ARFA = 2'b11;

  // Internal nets kept under fixed names so they can be probed hierarchically.
  logic [7:0]  RF_O1;
  logic [7:0]  RF_O2;
  logic [7:0]  ALU_Out;
  logic [7:0]  MemOut;
  logic [7:0]  MuxAOut;
  logic [7:0]  MuxBOut;
  logic [7:0]  MuxCOut;
  logic [7:0]  ARF_OutA;
  logic [7:0]  ARF_OutB;
  logic [3:0]  ALU_FlagOut;   // {Z, C, N, O}
  logic [15:0] IR_Out;

  // State: r_q[0..3] = R1..R4, t_q[0..3] = T1..T4, arf_q[0..3] = AR, SP, PCpast, PC.
  logic [7:0]  r_q   [4];
  logic [7:0]  t_q   [4];
  logic [7:0]  arf_q [4];
  logic [15:0] ir_q;
  logic        flag_z_q;
  logic        flag_c_q;
  logic        flag_n_q;
  logic        flag_o_q;

  // Memory contents start at zero and are deliberately untouched by Reset.
  logic [7:0]  mem_q [256] = '{default: 8'h00};

  // ALU working signals.
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  add_b;
  logic        add_cin;
  logic [8:0]  sum9;
  logic        alu_c;
  logic        alu_o;

  // Next value of an 8-bit register for a given function code.
  function automatic logic [7:0] reg8_next(input logic [1:0] fun,
                                           input logic [7:0] cur,
                                           input logic [7:0] din);
    logic [7:0] nxt;
    case (fun)
      FUN_DEC:  nxt = cur - 8'd1;
      FUN_INC:  nxt = cur + 8'd1;
      FUN_LOAD: nxt = din;
      default:  nxt = 8'h00;
    endcase
    return nxt;
  endfunction

  // Source selection shared by MuxA and MuxB.
  function automatic logic [7:0] src_mux(input logic [1:0] sel,
                                         input logic [7:0] alu,
                                         input logic [7:0] mem,
                                         input logic [7:0] ir_lo,
                                         input logic [7:0] arfa);
    logic [7:0] res;
    case (sel)
      SRC_ALU:  res = alu;
      SRC_MEM:  res = mem;
      SRC_IR:   res = ir_lo;
      default:  res = arfa;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------- RF
  // R1..R4 and T1..T4: every enabled register applies RF_FunSel, loading from MuxAOut.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        r_q[i] <= 8'h00;
        t_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (RF_RSel[3-i]) r_q[i] <= reg8_next(RF_FunSel, r_q[i], MuxAOut);
        if (RF_TSel[3-i]) t_q[i] <= reg8_next(RF_FunSel, t_q[i], MuxAOut);
      end
    end
  end

  // RF read ports: sel[2] picks the R bank, sel[1:0] picks the register within the bank.
  always_comb begin
    RF_O1 = RF_O1Sel[2] ? r_q[RF_O1Sel[1:0]] : t_q[RF_O1Sel[1:0]];
    RF_O2 = RF_O2Sel[2] ? r_q[RF_O2Sel[1:0]] : t_q[RF_O2Sel[1:0]];
  end

  // ---------------------------------------------------------------- ARF
  // AR, SP, PCpast, PC: enable bit3 maps to AR down to bit0 for PC; loads come from MuxBOut.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) arf_q[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ARF_RSel[3-i]) arf_q[i] <= reg8_next(ARF_FunSel, arf_q[i], MuxBOut);
      end
    end
  end

  // ARF read ports: the select code is the register index directly.
  always_comb begin
    ARF_OutA = arf_q[ARF_OutASel];
    ARF_OutB = arf_q[ARF_OutBSel];
  end

  // ---------------------------------------------------------------- IR
  // IR: load writes the memory byte into the half chosen by IR_LH; inc/dec/clear act on all 16 bits.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ir_q <= 16'h0000;
    end else if (IR_Enable) begin
      case (IR_FunSel)
        FUN_DEC:  ir_q <= ir_q - 16'd1;
        FUN_INC:  ir_q <= ir_q + 16'd1;
        FUN_LOAD: begin
          if (IR_LH) ir_q[15:8] <= MemOut;
          else       ir_q[7:0]  <= MemOut;
        end
        default:  ir_q <= 16'h0000;
      endcase
    end
  end

  assign IR_Out = ir_q;

  // ---------------------------------------------------------------- Muxes
  // Source muxes feeding RF loads (A), ARF loads (B) and the ALU A operand (C).
  always_comb begin
    MuxAOut = src_mux(MuxASel, ALU_Out, MemOut, IR_Out[7:0], ARF_OutA);
    MuxBOut = src_mux(MuxBSel, ALU_Out, MemOut, IR_Out[7:0], ARF_OutA);
    MuxCOut = MuxCSel ? RF_O1 : ARF_OutA;
  end

  // ---------------------------------------------------------------- ALU
  assign alu_a = MuxCOut;
  assign alu_b = RF_O2;

  // Shared adder: subtraction is A + ~B + 1, add-with-carry feeds the stored C flag in.
  always_comb begin
    add_b   = (ALU_FunSel == 4'h6) ? ~alu_b : alu_b;
    add_cin = 1'b0;
    if (ALU_FunSel == 4'h6)      add_cin = 1'b1;
    else if (ALU_FunSel == 4'h5) add_cin = ALU_FlagOut[2];
    sum9    = {1'b0, alu_a} + {1'b0, add_b} + {8'h00, add_cin};
  end

  // ALU result plus the C/O values to capture; codes that do not define C or O hold the stored flag.
  always_comb begin
    ALU_Out = 8'h00;
    alu_c   = ALU_FlagOut[2];
    alu_o   = ALU_FlagOut[0];
    case (ALU_FunSel)
      4'h0: ALU_Out = alu_a;
      4'h1: ALU_Out = alu_b;
      4'h2: ALU_Out = ~alu_a;
      4'h3: ALU_Out = ~alu_b;
      4'h4, 4'h5, 4'h6: begin
        ALU_Out = sum9[7:0];
        alu_c   = sum9[8];
        // Signed overflow: both addends share a sign that the result does not.
        alu_o   = (alu_a[7] == add_b[7]) && (sum9[7] != alu_a[7]);
      end
      4'h7: ALU_Out = alu_a & alu_b;
      4'h8: ALU_Out = alu_a | alu_b;
      4'h9: ALU_Out = alu_a ^ alu_b;
      4'hA: begin
        ALU_Out = {alu_a[6:0], 1'b0};
        alu_c   = alu_a[7];
      end
      4'hB: begin
        ALU_Out = {1'b0, alu_a[7:1]};
        alu_c   = alu_a[0];
      end
      4'hC: begin
        ALU_Out = {alu_a[6:0], 1'b0};
        alu_c   = alu_a[7];
        // Arithmetic left shift overflows when the sign bit changes.
        alu_o   = alu_a[7] ^ alu_a[6];
      end
      4'hD: begin
        ALU_Out = {alu_a[7], alu_a[7:1]};
        alu_c   = alu_a[0];
      end
      4'hE: begin
        ALU_Out = {alu_a[6:0], ALU_FlagOut[2]};
        alu_c   = alu_a[7];
      end
      default: begin
        ALU_Out = {ALU_FlagOut[2], alu_a[7:1]};
        alu_c   = alu_a[0];
      end
    endcase
  end

  // Flag register: captured every edge out of reset from the pre-edge ALU result.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_o_q <= 1'b0;
    end else begin
      flag_z_q <= (ALU_Out == 8'h00);
      flag_c_q <= alu_c;
      flag_n_q <= ALU_Out[7];
      flag_o_q <= alu_o;
    end
  end

  assign ALU_FlagOut = {flag_z_q, flag_c_q, flag_n_q, flag_o_q};

  // ---------------------------------------------------------------- Memory
  // Synchronous write of ALU_Out at address ARF_OutB when selected and writing.
  always_ff @(posedge Clock) begin
    if (!Mem_CS && Mem_WR) mem_q[ARF_OutB] <= ALU_Out;
  end

  // Asynchronous read; a same-cycle write only becomes visible after the edge.
  assign MemOut = Mem_CS ? 8'h00 : mem_q[ARF_OutB];

  // Probe-only bits with no internal reader.
  logic unused_probe_bits;
  assign unused_probe_bits = &{1'b0, IR_Out[15:8], ALU_FlagOut[3], ALU_FlagOut[1]};

endmodule

// File: tb/tb_alu_system.sv
// tb_alu_system: directed vectors with hand-computed expectations for alu_system.
// Inputs change 1 time unit after the rising edge; checks happen after a further settle delay.
// Internal nets are observed hierarchically since the design has no primary outputs.
module tb_alu_system;

  logic       Clock;
  logic       Reset;
  logic [2:0] RF_O1Sel;
  logic [2:0] RF_O2Sel;
  logic [1:0] RF_FunSel;
  logic [3:0] RF_RSel;
  logic [3:0] RF_TSel;
  logic [3:0] ALU_FunSel;
  logic [1:0] ARF_OutASel;
  logic [1:0] ARF_OutBSel;
  logic [1:0] ARF_FunSel;
  logic [3:0] ARF_RSel;
  logic       IR_LH;
  logic       IR_Enable;
  logic [1:0] IR_FunSel;
  logic       Mem_WR;
  logic       Mem_CS;
  logic [1:0] MuxASel;
  logic [1:0] MuxBSel;
  logic       MuxCSel;

  int n_tests = 0;
  int n_fail  = 0;

  alu_system dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .RF_O1Sel    (RF_O1Sel),
    .RF_O2Sel    (RF_O2Sel),
    .RF_FunSel   (RF_FunSel),
    .RF_RSel     (RF_RSel),
    .RF_TSel     (RF_TSel),
    .ALU_FunSel  (ALU_FunSel),
    .ARF_OutASel (ARF_OutASel),
    .ARF_OutBSel (ARF_OutBSel),
    .ARF_FunSel  (ARF_FunSel),
    .ARF_RSel    (ARF_RSel),
    .IR_LH       (IR_LH),
    .IR_Enable   (IR_Enable),
    .IR_FunSel   (IR_FunSel),
    .Mem_WR      (Mem_WR),
    .Mem_CS      (Mem_CS),
    .MuxASel     (MuxASel),
    .MuxBSel     (MuxBSel),
    .MuxCSel     (MuxCSel)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    RF_RSel   = 4'b0000;
    RF_TSel   = 4'b0000;
    ARF_RSel  = 4'b0000;
    IR_Enable = 1'b0;
    Mem_CS    = 1'b1;
    Mem_WR    = 1'b0;
  endtask

  // AR <- v by clearing and incrementing v times.
  task automatic set_ar(input int v);
    ARF_RSel   = 4'b1000;
    ARF_FunSel = 2'b11;
    tick();
    ARF_FunSel = 2'b01;
    repeat (v) tick();
    ARF_RSel   = 4'b0000;
  endtask

  // Load the R registers selected by rsel from AR through MuxA.
  task automatic load_r_from_ar(input logic [3:0] rsel);
    MuxASel     = 2'b11;
    ARF_OutASel = 2'b00;
    RF_FunSel   = 2'b10;
    RF_RSel     = rsel;
    tick();
    RF_RSel     = 4'b0000;
  endtask

  initial begin
    quiet();
    Reset = 1'b1;
    RF_O1Sel = 3'b100; RF_O2Sel = 3'b101; RF_FunSel = 2'b00;
    ALU_FunSel = 4'h0; ARF_OutASel = 2'b00; ARF_OutBSel = 2'b00; ARF_FunSel = 2'b00;
    IR_LH = 1'b0; IR_FunSel = 2'b00; MuxASel = 2'b00; MuxBSel = 2'b00; MuxCSel = 1'b1;

    // Reset with every register enabled for increment: reset must win.
    Reset = 1'b0;
    RF_FunSel = 2'b01; RF_RSel = 4'b1111; RF_TSel = 4'b1111;
    ARF_FunSel = 2'b01; ARF_RSel = 4'b1111;
    IR_Enable = 1'b1; IR_FunSel = 2'b01;
    tick(); tick();
    Reset = 1'b1;
    quiet();
    settle();
    chk("rst_r1",    {8'h00, dut.RF_O1},    16'h0000);
    chk("rst_ar",    {8'h00, dut.ARF_OutA}, 16'h0000);
    chk("rst_ir",    dut.IR_Out,            16'h0000);
    chk("rst_flags", {12'h000, dut.ALU_FlagOut}, 16'h0000);
    chk("rst_memout_cs1", {8'h00, dut.MemOut}, 16'h0000);

    // IR = 0x0025 by clear + 37 increments, then R1 <- IR[7:0] via MuxA.
    IR_Enable = 1'b1; IR_FunSel = 2'b11; tick();
    IR_FunSel = 2'b01; repeat (37) tick();
    IR_Enable = 1'b0;
    settle();
    chk("ir_0025", dut.IR_Out, 16'h0025);
    MuxASel = 2'b10; RF_FunSel = 2'b10; RF_RSel = 4'b1000; tick();
    RF_RSel = 4'b0000; RF_O1Sel = 3'b100; settle();
    chk("r1_load_ir", {8'h00, dut.RF_O1}, 16'h0025);
    RF_TSel = 4'b0100; tick();
    RF_TSel = 4'b0000; RF_O1Sel = 3'b000; RF_O2Sel = 3'b001; settle();
    chk("t1_untouched", {8'h00, dut.RF_O1}, 16'h0000);
    chk("t2_load_ir",   {8'h00, dut.RF_O2}, 16'h0025);

    // R2 = 1 by increment, R1 = 0x7F via AR; 0x7F + 0x01 overflows to 0x80.
    RF_FunSel = 2'b01; RF_RSel = 4'b0100; tick();
    RF_RSel = 4'b0000; RF_O2Sel = 3'b101; settle();
    chk("r2_inc", {8'h00, dut.RF_O2}, 16'h0001);
    set_ar(127);
    load_r_from_ar(4'b1000);
    MuxCSel = 1'b1; RF_O1Sel = 3'b100; RF_O2Sel = 3'b101; ALU_FunSel = 4'h4; settle();
    chk("add_7f_01", {8'h00, dut.ALU_Out}, 16'h0080);
    tick();
    chk("add_flags", {12'h000, dut.ALU_FlagOut}, 16'h0003);

    // R1 = R2 = 5: subtract gives zero with carry; ADC then uses C = 1.
    set_ar(5);
    load_r_from_ar(4'b1100);
    ALU_FunSel = 4'h6; settle();
    chk("sub_5_5", {8'h00, dut.ALU_Out}, 16'h0000);
    tick();
    chk("sub_flags", {12'h000, dut.ALU_FlagOut}, 16'h000C);
    ALU_FunSel = 4'h5; settle();
    chk("adc_cin1", {8'h00, dut.ALU_Out}, 16'h000B);
    tick();
    chk("adc_flags", {12'h000, dut.ALU_FlagOut}, 16'h0000);

    // R2 = 4 by decrement; logic ops with A = 5, B = 4.
    RF_FunSel = 2'b00; RF_RSel = 4'b0100; tick();
    RF_RSel = 4'b0000; settle();
    chk("r2_dec", {8'h00, dut.RF_O2}, 16'h0004);
    ALU_FunSel = 4'h7; settle(); chk("and", {8'h00, dut.ALU_Out}, 16'h0004);
    ALU_FunSel = 4'h8; settle(); chk("or",  {8'h00, dut.ALU_Out}, 16'h0005);
    ALU_FunSel = 4'h9; settle(); chk("xor", {8'h00, dut.ALU_Out}, 16'h0001);
    ALU_FunSel = 4'h2; settle(); chk("nota", {8'h00, dut.ALU_Out}, 16'h00FA);
    ALU_FunSel = 4'h3; settle(); chk("notb", {8'h00, dut.ALU_Out}, 16'h00FB);
    ALU_FunSel = 4'h1; settle(); chk("passb", {8'h00, dut.ALU_Out}, 16'h0004);
    // MuxC = 0 takes ARF_OutA (PC, still 0) instead of R1.
    ALU_FunSel = 4'h0; MuxCSel = 1'b0; ARF_OutASel = 2'b11; settle();
    chk("muxc_arf", {8'h00, dut.ALU_Out}, 16'h0000);
    MuxCSel = 1'b1; ARF_OutASel = 2'b00;

    // R1 <- ~R1 through MuxA from ALU_Out: captures the pre-edge value 0xFA.
    ALU_FunSel = 4'h2; MuxASel = 2'b00; RF_FunSel = 2'b10; RF_RSel = 4'b1000; tick();
    RF_RSel = 4'b0000; settle();
    chk("r1_self_not", {8'h00, dut.RF_O1}, 16'h00FA);

    // Shifts on A = 0xFA.
    ALU_FunSel = 4'hB; settle(); chk("lsr", {8'h00, dut.ALU_Out}, 16'h007D);
    tick(); chk("lsr_c", {15'h0000, dut.ALU_FlagOut[2]}, 16'h0000);
    ALU_FunSel = 4'hF; settle(); chk("csr_c0", {8'h00, dut.ALU_Out}, 16'h007D);
    tick();
    ALU_FunSel = 4'hC; settle(); chk("asl", {8'h00, dut.ALU_Out}, 16'h00F4);
    tick(); chk("asl_flags", {12'h000, dut.ALU_FlagOut}, 16'h0006);
    ALU_FunSel = 4'hE; settle(); chk("csl_c1", {8'h00, dut.ALU_Out}, 16'h00F5);
    tick(); chk("csl_c", {15'h0000, dut.ALU_FlagOut[2]}, 16'h0001);
    ALU_FunSel = 4'hF; settle(); chk("csr_c1", {8'h00, dut.ALU_Out}, 16'h00FD);
    tick(); chk("csr_flags", {12'h000, dut.ALU_FlagOut}, 16'h0002);
    ALU_FunSel = 4'hD; settle(); chk("asr", {8'h00, dut.ALU_Out}, 16'h00FD);
    ALU_FunSel = 4'hA; settle(); chk("lsl", {8'h00, dut.ALU_Out}, 16'h00F4);

    // R3 = 0x10; AR <- ALU_Out via MuxB.
    RF_RSel = 4'b0010; RF_FunSel = 2'b11; tick();
    RF_FunSel = 2'b01; repeat (16) tick();
    RF_RSel = 4'b0000;
    ALU_FunSel = 4'h0; MuxCSel = 1'b1; RF_O1Sel = 3'b110;
    MuxBSel = 2'b00; ARF_FunSel = 2'b10; ARF_RSel = 4'b1000; tick();
    ARF_RSel = 4'b0000; ARF_OutASel = 2'b00; settle();
    chk("ar_muxb", {8'h00, dut.ARF_OutA}, 16'h0010);

    // R3 = 0x3C; write it to mem[0x10], read back, then deselect.
    RF_RSel = 4'b0010; RF_FunSel = 2'b01; repeat (44) tick();
    RF_RSel = 4'b0000; ARF_OutBSel = 2'b00; settle();
    chk("alu_3c", {8'h00, dut.ALU_Out}, 16'h003C);
    Mem_CS = 1'b0; Mem_WR = 1'b1; settle();
    chk("mem_old_data", {8'h00, dut.MemOut}, 16'h0000);
    tick();
    Mem_WR = 1'b0; settle();
    chk("mem_read_3c", {8'h00, dut.MemOut}, 16'h003C);
    Mem_CS = 1'b1; settle();
    chk("mem_cs_off", {8'h00, dut.MemOut}, 16'h0000);
    ARF_FunSel = 2'b01; ARF_RSel = 4'b1000; tick();
    ARF_RSel = 4'b0000; Mem_CS = 1'b0; settle();
    chk("mem_other_addr", {8'h00, dut.MemOut}, 16'h0000);
    Mem_CS = 1'b1;

    // R3 = 0xAB; write to mem[0x11] to source the IR load.
    RF_RSel = 4'b0010; RF_FunSel = 2'b01; repeat (111) tick();
    RF_RSel = 4'b0000; settle();
    chk("alu_ab", {8'h00, dut.ALU_Out}, 16'h00AB);
    Mem_CS = 1'b0; Mem_WR = 1'b1; tick();
    Mem_WR = 1'b0; settle();
    chk("mem_read_ab", {8'h00, dut.MemOut}, 16'h00AB);

    // IR: clear, decrement wraps to 0xFFFF, half loads, 16-bit increment carry, enable gating.
    IR_Enable = 1'b1; IR_FunSel = 2'b11; tick();
    IR_FunSel = 2'b00; tick();
    IR_Enable = 1'b0; settle();
    chk("ir_dec_wrap", dut.IR_Out, 16'hFFFF);
    IR_Enable = 1'b1; IR_FunSel = 2'b10; IR_LH = 1'b1; tick();
    chk("ir_load_hi", dut.IR_Out, 16'hABFF);
    IR_FunSel = 2'b01; tick();
    chk("ir_inc_carry", dut.IR_Out, 16'hAC00);
    IR_FunSel = 2'b10; IR_LH = 1'b0; tick();
    chk("ir_load_lo", dut.IR_Out, 16'hACAB);
    IR_Enable = 1'b0; IR_FunSel = 2'b11; tick();
    chk("ir_disabled", dut.IR_Out, 16'hACAB);
    Mem_CS = 1'b1;

    // PC: clear, decrement wraps to 0xFF, increment wraps to 0x00; PCpast untouched.
    ARF_RSel = 4'b0001; ARF_FunSel = 2'b11; tick();
    ARF_FunSel = 2'b00; tick();
    ARF_OutASel = 2'b11; settle();
    chk("pc_dec_wrap", {8'h00, dut.ARF_OutA}, 16'h00FF);
    ARF_FunSel = 2'b01; tick();
    chk("pc_inc_wrap", {8'h00, dut.ARF_OutA}, 16'h0000);
    ARF_RSel = 4'b0000; ARF_OutBSel = 2'b10; settle();
    chk("pcpast_idle", {8'h00, dut.ARF_OutB}, 16'h0000);

    // Mid-operation reset with increments pending: everything clears, memory keeps its data.
    ARF_OutASel = 2'b00;
    Reset = 1'b0;
    RF_FunSel = 2'b01; RF_RSel = 4'b1111; RF_TSel = 4'b1111;
    ARF_FunSel = 2'b01; ARF_RSel = 4'b1111;
    IR_Enable = 1'b1; IR_FunSel = 2'b01;
    tick();
    Reset = 1'b1;
    quiet();
    RF_O1Sel = 3'b100; RF_O2Sel = 3'b110; settle();
    chk("rst2_r1",    {8'h00, dut.RF_O1},    16'h0000);
    chk("rst2_r3",    {8'h00, dut.RF_O2},    16'h0000);
    chk("rst2_ar",    {8'h00, dut.ARF_OutA}, 16'h0000);
    chk("rst2_ir",    dut.IR_Out,            16'h0000);
    chk("rst2_flags", {12'h000, dut.ALU_FlagOut}, 16'h0000);
    RF_O1Sel = 3'b001; settle();
    chk("rst2_t2",    {8'h00, dut.RF_O1},    16'h0000);
    chk("rst2_mem_kept", {8'h00, dut.mem_q[8'h10]}, 16'h003C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
